// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer and the pipeline that hosts it.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;

  // Entry address is held at SB_AW bits; instantiations keep AW <= SB_AW.
  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [31:0]      data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the buffered stores for load forwarding.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW
) (
  input  sb_entry_t [DEPTH-1:0]    entries,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            ld_addr,
  output logic                     hit,
  output logic [31:0]              data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [SB_AW-1:0] WORD_MASK = ~SB_AW'(3);

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count) && entries[head + PW'(i)].valid &&
          (((entries[head + PW'(i)].addr ^ SB_AW'(ld_addr)) & WORD_MASK) == '0)) begin
        hit  = 1'b1;
        data = entries[head + PW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular FIFO of pending word stores with in-order drain and load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit,
  output logic [31:0]            ld_data,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  push;
  logic                  pop;

  assign st_ready  = (count != (PW+1)'(DEPTH));
  assign mem_we    = (count != '0);
  assign mem_addr  = AW'(entries[head].addr);
  assign mem_wdata = entries[head].data;
  assign push      = st_valid && st_ready;
  assign pop       = mem_we && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      // head == tail with both active is impossible: push needs !full, pop needs !empty.
      if (push) begin
        entries[tail] <= '{valid: 1'b1, addr: SB_AW'(st_addr), data: st_data};
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  sb_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fwd (
    .entries(entries),
    .head   (head),
    .count  (count),
    .ld_addr(ld_addr),
    .hit    (ld_hit),
    .data   (ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed-vector bench for store_buffer: table of per-cycle stimulus and expected outputs.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [2:0]  count;

  store_buffer #(
    .DEPTH(4),
    .AW   (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied for one cycle; expectations describe outputs before that cycle's edge.
  typedef struct {
    bit          chk;
    bit          rst;
    bit          sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [31:0] la;
    bit          mr;
    logic [31:0] e_cnt;
    bit          e_rdy;
    bit          e_we;
    logic [31:0] e_ma;
    logic [31:0] e_md;
    bit          e_hit;
    logic [31:0] e_ld;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];

  task automatic add(input bit c, input bit r, input bit sv, input logic [31:0] sa,
                     input logic [31:0] sd, input logic [31:0] la, input bit mr,
                     input logic [31:0] ecnt, input bit erdy, input bit ewe,
                     input logic [31:0] ema, input logic [31:0] emd, input bit ehit,
                     input logic [31:0] eld);
    vec_t v;
    v = '{c, r, sv, sa, sd, la, mr, ecnt, erdy, ewe, ema, emd, ehit, eld};
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic [31:0] la, input bit mr);
    @(negedge clk);
    rst       = r;
    st_valid  = sv;
    st_addr   = sa;
    st_data   = sd;
    ld_addr   = la;
    mem_ready = mr;
    #1;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0; mem_ready = 1'b0;

    //   chk r  sv sa        sd            la        mr cnt rdy we ma        md            hit ld
    add(0, 1, 0, 32'h0,    32'h0,        32'h0,    0, 0, 1, 0, 32'h0,    32'h0,        0, 32'h0);
    add(1, 0, 1, 32'h10,   32'hAAAA0001, 32'h10,   0, 0, 1, 0, 32'h0,    32'h0,        0, 32'h0);
    add(1, 0, 0, 32'h0,    32'h0,        32'h10,   0, 1, 1, 1, 32'h10,   32'hAAAA0001, 1, 32'hAAAA0001);
    add(1, 0, 0, 32'h0,    32'h0,        32'h10,   1, 1, 1, 1, 32'h10,   32'hAAAA0001, 1, 32'hAAAA0001);
    add(1, 0, 1, 32'h20,   32'h1,        32'h22,   0, 0, 1, 0, 32'h0,    32'h0,        0, 32'h0);
    add(1, 0, 1, 32'h20,   32'h2,        32'h22,   0, 1, 1, 1, 32'h20,   32'h1,        1, 32'h1);
    add(1, 0, 1, 32'h24,   32'h3,        32'h22,   0, 2, 1, 1, 32'h20,   32'h1,        1, 32'h2);
    add(1, 0, 0, 32'h0,    32'h0,        32'h22,   0, 3, 1, 1, 32'h20,   32'h1,        1, 32'h2);
    add(1, 0, 0, 32'h0,    32'h0,        32'h24,   1, 3, 1, 1, 32'h20,   32'h1,        1, 32'h3);
    add(1, 0, 0, 32'h0,    32'h0,        32'h20,   1, 2, 1, 1, 32'h20,   32'h2,        1, 32'h2);
    add(1, 0, 0, 32'h0,    32'h0,        32'h20,   1, 1, 1, 1, 32'h24,   32'h3,        0, 32'h0);
    add(1, 0, 1, 32'h100,  32'hA0,       32'h0,    0, 0, 1, 0, 32'h0,    32'h0,        0, 32'h0);
    add(1, 0, 1, 32'h104,  32'hA1,       32'h0,    0, 1, 1, 1, 32'h100,  32'hA0,       0, 32'h0);
    add(1, 0, 1, 32'h108,  32'hA2,       32'h0,    0, 2, 1, 1, 32'h100,  32'hA0,       0, 32'h0);
    add(1, 0, 1, 32'h10C,  32'hA3,       32'h0,    0, 3, 1, 1, 32'h100,  32'hA0,       0, 32'h0);
    add(1, 0, 1, 32'h110,  32'hA4,       32'h110,  0, 4, 0, 1, 32'h100,  32'hA0,       0, 32'h0);
    add(1, 0, 1, 32'h110,  32'hA4,       32'h10C,  1, 4, 0, 1, 32'h100,  32'hA0,       1, 32'hA3);
    add(1, 0, 0, 32'h0,    32'h0,        32'h110,  0, 3, 1, 1, 32'h104,  32'hA1,       0, 32'h0);
    add(1, 1, 1, 32'h200,  32'hB0,       32'h104,  1, 3, 1, 1, 32'h104,  32'hA1,       1, 32'hA1);
    add(1, 0, 0, 32'h0,    32'h0,        32'h104,  0, 0, 1, 0, 32'h0,    32'h0,        0, 32'h0);
    add(1, 0, 1, 32'h40,   32'hC0,       32'h40,   0, 0, 1, 0, 32'h0,    32'h0,        0, 32'h0);
    add(1, 0, 0, 32'h0,    32'h0,        32'h40,   0, 1, 1, 1, 32'h40,   32'hC0,       1, 32'hC0);
    add(1, 0, 0, 32'h0,    32'h0,        32'h40,   1, 1, 1, 1, 32'h40,   32'hC0,       1, 32'hC0);
    add(1, 0, 0, 32'h0,    32'h0,        32'h40,   0, 0, 1, 0, 32'h0,    32'h0,        0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].la, vecs[i].mr);
      if (vecs[i].chk) begin
        check($sformatf("v%0d count", i),   32'(count),    vecs[i].e_cnt);
        check($sformatf("v%0d st_ready", i), 32'(st_ready), 32'(vecs[i].e_rdy));
        check($sformatf("v%0d mem_we", i),  32'(mem_we),   32'(vecs[i].e_we));
        if (vecs[i].e_we) begin
          check($sformatf("v%0d mem_addr", i),  mem_addr,  vecs[i].e_ma);
          check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_md);
        end
        check($sformatf("v%0d ld_hit", i),  32'(ld_hit),   32'(vecs[i].e_hit));
        check($sformatf("v%0d ld_data", i), ld_data,       vecs[i].e_ld);
      end
    end

    // Two entries resident, then ten push+pop cycles so the pointers wrap repeatedly.
    drive(0, 1, 32'h300, 32'hD0, 32'h0, 0);
    q.push_back(32'hD0);
    drive(0, 1, 32'h304, 32'hD1, 32'h0, 0);
    q.push_back(32'hD1);
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 32'h308 + 32'(4 * k), 32'hD2 + 32'(k), 32'h0, 1);
      check($sformatf("wrap%0d count", k), 32'(count), 32'd2);
      check($sformatf("wrap%0d mem_wdata", k), mem_wdata, q[0]);
      void'(q.pop_front());
      q.push_back(32'hD2 + 32'(k));
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 32'h0, 32'h0, 32'h0, 1);
      check($sformatf("drain%0d mem_we", k), 32'(mem_we), 32'd1);
      check($sformatf("drain%0d mem_wdata", k), mem_wdata, q[0]);
      void'(q.pop_front());
    end
    drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
    check("final count", 32'(count), 32'd0);
    check("final mem_we", 32'(mem_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
